// File: rtl/shift_reg_bank.sv
// Multi-lane synchronous shift register with a runtime tap, recirculate ring,
// hold/clear modes and a saturating fill counter.

module shift_reg_lane #(
   parameter int DEPTH = 128,
   parameter int LEN_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift,
   input  logic             recirc,
   input  logic [LEN_W-1:0] len,
   input  logic             din,
   output logic             tap
);
   logic [DEPTH-1:0] stage;

   assign tap = stage[len];

   // Recirculate feeds back the tap selected by len on this very edge.
   always_ff @(posedge clk) begin
      if (rst || clr)
         stage <= '0;
      else if (shift)
         stage <= {stage[DEPTH-2:0], din};
      else if (recirc)
         stage <= {stage[DEPTH-2:0], tap};
   end
endmodule

module shift_reg_bank #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 128,
   parameter int LEN_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [LEN_W-1:0] len,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [LEN_W:0]   fill_cnt,
   output logic             filled
);
   typedef enum logic [1:0] {
      M_SHIFT  = 2'b00,
      M_RECIRC = 2'b01,
      M_HOLD   = 2'b10,
      M_CLEAR  = 2'b11
   } mode_e;

   localparam logic [LEN_W:0] FULL = (LEN_W+1)'(DEPTH);

   logic clr, shift, recirc;

   assign clr    = (mode == M_CLEAR);
   assign shift  = en && (mode == M_SHIFT);
   assign recirc = en && (mode == M_RECIRC);

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_lane
         shift_reg_lane #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .shift  (shift),
            .recirc (recirc),
            .len    (len),
            .din    (din[i]),
            .tap    (dout[i])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || clr)
         fill_cnt <= '0;
      else if (shift && (fill_cnt != FULL))
         fill_cnt <= fill_cnt + 1'b1;
   end

   assign filled = (fill_cnt > {1'b0, len});
endmodule

// File: tb/tb_shift_reg_bank.sv
// Directed bench for shift_reg_bank (WIDTH=8, DEPTH=16).

module tb_shift_reg_bank;
   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int LEN_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [1:0]       mode;
   logic [LEN_W-1:0] len;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic [LEN_W:0]   fill_cnt;
   logic             filled;

   int vectors = 0;
   int miscompares = 0;

   shift_reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .len      (len),
      .din      (din),
      .dout     (dout),
      .fill_cnt (fill_cnt),
      .filled   (filled)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      mode = 2'b11; en = 1'b0;
      tick();
      mode = 2'b10;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; mode = 2'b10; len = 4'd3; din = '0;
      tick();
      tick();
      vectors++;
      if (dout !== 8'h00) begin
         miscompares++; $display("FAIL reset_dout got %h want 00", dout);
      end
      vectors++;
      if (fill_cnt !== 5'd0) begin
         miscompares++; $display("FAIL reset_fill got %0d want 0", fill_cnt);
      end
      vectors++;
      if (filled !== 1'b0) begin
         miscompares++; $display("FAIL reset_filled got %b want 0", filled);
      end
      rst = 1'b0;
   endtask

   task automatic test_latency();
      logic [7:0] words [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      logic [7:0] exp_d [5]  = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
      logic       exp_f [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      len = 4'd3; mode = 2'b00; en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         din = words[k];
         tick();
         vectors++;
         if (dout !== exp_d[k]) begin
            miscompares++; $display("FAIL latency_dout edge %0d got %h want %h", k+1, dout, exp_d[k]);
         end
         vectors++;
         if (filled !== exp_f[k]) begin
            miscompares++; $display("FAIL latency_filled edge %0d got %b want %b", k+1, filled, exp_f[k]);
         end
      end
   endtask

   task automatic test_recirc();
      logic [7:0] seq [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
      mode = 2'b01; en = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         vectors++;
         if (dout !== seq[e % 4]) begin
            miscompares++; $display("FAIL recirc_dout edge %0d got %h want %h", e, dout, seq[e % 4]);
         end
         vectors++;
         if (fill_cnt !== 5'd5) begin
            miscompares++; $display("FAIL recirc_fill edge %0d got %0d want 5", e, fill_cnt);
         end
      end
   endtask

   task automatic test_gaps_hold();
      logic       s_en   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0] s_mode [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
      logic [7:0] s_din  [9] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18, 8'h29};
      logic [7:0] e_dout [9] = '{8'h00, 8'h00, 8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hC3, 8'hC3};
      logic [4:0] e_fill [9] = '{5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd3, 5'd3};
      do_clear();
      len = 4'd1;
      for (int k = 0; k < 9; k++) begin
         en = s_en[k]; mode = s_mode[k]; din = s_din[k];
         tick();
         vectors++;
         if (dout !== e_dout[k]) begin
            miscompares++; $display("FAIL gaps_dout step %0d got %h want %h", k, dout, e_dout[k]);
         end
         vectors++;
         if (fill_cnt !== e_fill[k]) begin
            miscompares++; $display("FAIL gaps_fill step %0d got %0d want %0d", k, fill_cnt, e_fill[k]);
         end
      end
   endtask

   task automatic test_len_change();
      logic [3:0] lens  [3] = '{4'd15, 4'd0, 4'd7};
      logic [7:0] exp_d [3] = '{8'h01, 8'h10, 8'h09};
      do_clear();
      len = 4'd15; mode = 2'b00; en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         din = 8'(k);
         tick();
      end
      mode = 2'b10; en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         len = lens[k];
         #1;
         vectors++;
         if (dout !== exp_d[k]) begin
            miscompares++; $display("FAIL len_dout len %0d got %h want %h", lens[k], dout, exp_d[k]);
         end
         vectors++;
         if (filled !== 1'b1) begin
            miscompares++; $display("FAIL len_filled len %0d got %b want 1", lens[k], filled);
         end
         tick();
      end
   endtask

   task automatic test_saturate_clear();
      logic [4:0] exp_f;
      do_clear();
      len = 4'd7; mode = 2'b00; en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         din = 8'(k + 8'h40);
         tick();
         exp_f = (k + 1 < DEPTH) ? 5'(k + 1) : 5'(DEPTH);
         vectors++;
         if (fill_cnt !== exp_f) begin
            miscompares++; $display("FAIL sat_fill shift %0d got %0d want %0d", k+1, fill_cnt, exp_f);
         end
      end
      vectors++;
      if (dout !== 8'h60) begin
         miscompares++; $display("FAIL sat_dout got %h want 60", dout);
      end
      mode = 2'b11; en = 1'b0;
      tick();
      mode = 2'b10;
      vectors++;
      if (fill_cnt !== 5'd0) begin
         miscompares++; $display("FAIL clear_fill got %0d want 0", fill_cnt);
      end
      vectors++;
      if (dout !== 8'h00) begin
         miscompares++; $display("FAIL clear_dout got %h want 00", dout);
      end
      vectors++;
      if (filled !== 1'b0) begin
         miscompares++; $display("FAIL clear_filled got %b want 0", filled);
      end
   endtask

   task automatic test_reset_priority();
      len = 4'd15; mode = 2'b00; en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         din = 8'(8'h80 + k);
         tick();
      end
      vectors++;
      if (filled !== 1'b1) begin
         miscompares++; $display("FAIL rstp_prefill got %b want 1", filled);
      end
      rst = 1'b1; din = 8'hFF;
      tick();
      rst = 1'b0; mode = 2'b10; en = 1'b0;
      vectors++;
      if (dout !== 8'h00) begin
         miscompares++; $display("FAIL rstp_dout got %h want 00", dout);
      end
      vectors++;
      if (fill_cnt !== 5'd0) begin
         miscompares++; $display("FAIL rstp_fill got %0d want 0", fill_cnt);
      end
      vectors++;
      if (filled !== 1'b0) begin
         miscompares++; $display("FAIL rstp_filled got %b want 0", filled);
      end
      len = 4'd0;
      #1;
      vectors++;
      if (dout !== 8'h00) begin
         miscompares++; $display("FAIL rstp_stage0 got %h want 00", dout);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 2'b10; len = '0; din = '0;
      test_reset();
      test_latency();
      test_recirc();
      test_gaps_hold();
      test_len_change();
      test_saturate_clear();
      test_reset_priority();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
